// File: rtl/l2_reqs_mshr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : l2_reqs_mshr                                                      |
// | Outstanding L2 request table with lowest-free allocation, key lookup, set  |
// | conflict, invack counting and forward-stall tracking.                      |
// | Option : L2_REQS_MSHR_PERF_EN adds o_peak_count / o_reject_cnt.            |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module l2_reqs_mshr #(
   parameter int N_REQS      = 4,
   parameter int TAG_BITS    = 20,
   parameter int SET_BITS    = 8,
   parameter int WAY_BITS    = 3,
   parameter int STATE_BITS  = 4,
   parameter int LINE_BITS   = 128,
   parameter int INVACK_BITS = 4,
   parameter int ISD_ST      = 4,
   parameter int MIA_ST      = 9,
   localparam int IDX_BITS   = $clog2(N_REQS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_alloc_valid,
   input  logic [TAG_BITS-1:0]    i_alloc_tag,
   input  logic [SET_BITS-1:0]    i_alloc_set,
   input  logic [WAY_BITS-1:0]    i_alloc_way,
   input  logic [STATE_BITS-1:0]  i_alloc_state,
   output logic                   o_alloc_ready,
   output logic [IDX_BITS-1:0]    o_alloc_idx,
   input  logic                   i_upd_valid,
   input  logic [IDX_BITS-1:0]    i_upd_idx,
   input  logic                   i_upd_state_en,
   input  logic [STATE_BITS-1:0]  i_upd_state,
   input  logic                   i_upd_line_en,
   input  logic [LINE_BITS-1:0]   i_upd_line,
   input  logic                   i_inv_load,
   input  logic [INVACK_BITS-1:0] i_inv_load_val,
   input  logic                   i_inv_dec,
   input  logic [TAG_BITS-1:0]    i_lkp_tag,
   input  logic [SET_BITS-1:0]    i_lkp_set,
   output logic                   o_lkp_hit,
   output logic [IDX_BITS-1:0]    o_lkp_idx,
   input  logic [SET_BITS-1:0]    i_conf_set,
   output logic                   o_conf_hit,
   input  logic [IDX_BITS-1:0]    i_rd_idx,
   output logic [STATE_BITS-1:0]  o_rd_state,
   output logic [TAG_BITS-1:0]    o_rd_tag,
   output logic [SET_BITS-1:0]    o_rd_set,
   output logic [WAY_BITS-1:0]    o_rd_way,
   output logic [LINE_BITS-1:0]   o_rd_line,
   output logic [INVACK_BITS-1:0] o_rd_invack,
   input  logic                   i_fwd_valid,
   input  logic [1:0]             i_fwd_kind,
   output logic                   o_fwd_stall,
   output logic [IDX_BITS-1:0]    o_fwd_stall_idx,
   output logic [IDX_BITS:0]      o_count,
   output logic                   o_full,
   output logic                   o_empty
`ifdef L2_REQS_MSHR_PERF_EN
   ,
   output logic [IDX_BITS:0]      o_peak_count,
   output logic [15:0]            o_reject_cnt
`endif
);

   localparam logic [1:0] c_KIND_PUTACK = 2'd1;
   localparam logic [1:0] c_KIND_INV    = 2'd2;

   logic [STATE_BITS-1:0]  r_state  [N_REQS];
   logic [TAG_BITS-1:0]    r_tag    [N_REQS];
   logic [SET_BITS-1:0]    r_set    [N_REQS];
   logic [WAY_BITS-1:0]    r_way    [N_REQS];
   logic [LINE_BITS-1:0]   r_line   [N_REQS];
   logic [INVACK_BITS-1:0] r_invack [N_REQS];
   logic [IDX_BITS:0]      r_count;
   logic                   r_fwd_stall;
   logic [IDX_BITS-1:0]    r_fwd_stall_idx;

   logic                   w_alloc_fire;
   logic                   w_dealloc;
   logic [IDX_BITS:0]      w_count_nxt;

   // Lowest-index priority: scan downward so the smallest match is written last.
   always_comb begin
      o_alloc_ready = 1'b0;
      o_alloc_idx   = '0;
      o_lkp_hit     = 1'b0;
      o_lkp_idx     = '0;
      o_conf_hit    = 1'b0;
      for (int i = N_REQS-1; i >= 0; i--) begin
         if (r_state[i] == '0) begin
            o_alloc_ready = 1'b1;
            o_alloc_idx   = IDX_BITS'(i);
         end else begin
            if (r_tag[i] == i_lkp_tag && r_set[i] == i_lkp_set) begin
               o_lkp_hit = 1'b1;
               o_lkp_idx = IDX_BITS'(i);
            end
            if (r_set[i] == i_conf_set) begin
               o_conf_hit = 1'b1;
            end
         end
      end
   end

   assign o_rd_state      = r_state[i_rd_idx];
   assign o_rd_tag        = r_tag[i_rd_idx];
   assign o_rd_set        = r_set[i_rd_idx];
   assign o_rd_way        = r_way[i_rd_idx];
   assign o_rd_line       = r_line[i_rd_idx];
   assign o_rd_invack     = r_invack[i_rd_idx];
   assign o_fwd_stall     = r_fwd_stall;
   assign o_fwd_stall_idx = r_fwd_stall_idx;
   assign o_count         = r_count;
   assign o_full          = (r_count == (IDX_BITS+1)'(N_REQS));
   assign o_empty         = (r_count == '0);

   assign w_alloc_fire = i_alloc_valid & o_alloc_ready;
   // The allocated slot is always free, so a dealloc never lands on it.
   assign w_dealloc    = i_upd_valid & i_upd_state_en & (i_upd_state == '0) &
                         (r_state[i_upd_idx] != '0);

   always_comb begin
      w_count_nxt = r_count;
      if (w_alloc_fire && !w_dealloc) begin
         w_count_nxt = r_count + 1'b1;
      end else if (!w_alloc_fire && w_dealloc) begin
         w_count_nxt = r_count - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_REQS; i++) begin
            r_state[i]  <= '0;
            r_tag[i]    <= '0;
            r_set[i]    <= '0;
            r_way[i]    <= '0;
            r_line[i]   <= '0;
            r_invack[i] <= '0;
         end
         r_count         <= '0;
         r_fwd_stall     <= 1'b0;
         r_fwd_stall_idx <= '0;
      end else begin
         for (int i = 0; i < N_REQS; i++) begin
            if (w_alloc_fire && o_alloc_idx == IDX_BITS'(i)) begin
               r_state[i]  <= i_alloc_state;
               r_tag[i]    <= i_alloc_tag;
               r_set[i]    <= i_alloc_set;
               r_way[i]    <= i_alloc_way;
               r_line[i]   <= '0;
               r_invack[i] <= '1;
            end else if (i_upd_valid && i_upd_idx == IDX_BITS'(i)) begin
               if (i_upd_state_en) r_state[i] <= i_upd_state;
               if (i_upd_line_en)  r_line[i]  <= i_upd_line;
               if (i_inv_load) begin
                  r_invack[i] <= i_inv_load_val;
               end else if (i_inv_dec && r_invack[i] != '0) begin
                  r_invack[i] <= r_invack[i] - INVACK_BITS'(1);
               end
            end
         end
         r_count <= w_count_nxt;
         if (i_fwd_valid) begin
            if (o_lkp_hit) begin
               r_fwd_stall_idx <= o_lkp_idx;
               case (i_fwd_kind)
                  c_KIND_PUTACK: r_fwd_stall <= 1'b0;
                  c_KIND_INV:    r_fwd_stall <= (r_state[o_lkp_idx] == STATE_BITS'(ISD_ST));
                  default:       r_fwd_stall <= (r_state[o_lkp_idx] != STATE_BITS'(MIA_ST));
               endcase
            end else begin
               r_fwd_stall <= 1'b0;
            end
         end else if (w_dealloc && i_upd_idx == r_fwd_stall_idx) begin
            r_fwd_stall <= 1'b0;
         end
      end
   end

`ifdef L2_REQS_MSHR_PERF_EN
   logic [IDX_BITS:0] r_peak_count;
   logic [15:0]       r_reject_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_peak_count <= '0;
         r_reject_cnt <= '0;
      end else begin
         if (w_count_nxt > r_peak_count) r_peak_count <= w_count_nxt;
         if (i_alloc_valid && !o_alloc_ready && r_reject_cnt != 16'hFFFF) begin
            r_reject_cnt <= r_reject_cnt + 16'd1;
         end
      end
   end

   assign o_peak_count = r_peak_count;
   assign o_reject_cnt = r_reject_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/l2_reqs_mshr.md
Name: l2_reqs_mshr

Overview:
Parametrised L2 request buffer (MSHR): N_REQS-entry table of outstanding CPU misses and flushes.
- Allocates the lowest free entry and provides tag/set lookup and set-conflict detection.
- Counts invalidation acks per entry; tracks forward-stall state in registers.
- Adds occupancy, full and empty status.
- Sits between the L2 input arbiter/FSM and the tag/data arrays.

Parameters:
N_REQS, 4, entries (power of two, 2..16); IDX_BITS = clog2(N_REQS)
TAG_BITS, 20, tag width
SET_BITS, 8, set index width
WAY_BITS, 3, way width
STATE_BITS, 4, unstable-state width; encoding 0 = INVALID (entry free)
LINE_BITS, 128, cache line width
INVACK_BITS, 4, invack counter width
ISD_ST, 4, encoding of ISD
MIA_ST, 9, encoding of MIA

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
alloc_valid  in  1  allocate entry this cycle
alloc_tag / alloc_set / alloc_way  in  TAG_BITS/SET_BITS/WAY_BITS  new entry address
alloc_state  in  STATE_BITS  initial state (non-zero)
alloc_ready  out  1  a free entry exists (comb)
alloc_idx  out  IDX_BITS  lowest free index (comb)
upd_valid  in  1  update entry upd_idx
upd_idx  in  IDX_BITS  target entry
upd_state_en / upd_state  in  1/STATE_BITS  write state; 0 deallocates
upd_line_en / upd_line  in  1/LINE_BITS  write line
inv_load / inv_load_val  in  1/INVACK_BITS  load invack count
inv_dec  in  1  decrement invack count
lkp_tag / lkp_set  in  TAG_BITS/SET_BITS  lookup key
lkp_hit / lkp_idx  out  1/IDX_BITS  valid entry matching key (comb)
conf_set  in  SET_BITS  set to check
conf_hit  out  1  some valid entry has set == conf_set (comb)
rd_idx  in  IDX_BITS  read select
rd_state/rd_tag/rd_set/rd_way/rd_line/rd_invack  out  various  entry rd_idx fields (comb)
fwd_valid / fwd_kind  in  1/2  forward probe using lkp_tag/lkp_set; kind 0=other, 1=PUTACK, 2=INV
fwd_stall / fwd_stall_idx  out  1/IDX_BITS  registered forward stall and entry
count  out  IDX_BITS+1  valid entries (registered)
full / empty  out  1  count == N_REQS / count == 0

Behaviour:
- Reset: all entry fields 0 (all INVALID); count 0, empty 1, full 0, fwd_stall 0, fwd_stall_idx 0.
- Allocate: alloc_valid & alloc_ready writes tag/set/way/state at alloc_idx on the next edge. line is cleared to 0 and invack to all-ones (max). alloc_valid while !alloc_ready is ignored; no state changes.
- alloc_idx: lowest index with state 0. Its value is don't-care when full.
- Update: upd_valid with upd_state_en/upd_line_en writes the selected field on the next edge.
- Dealloc: writing state 0 to a valid entry. count decrements.
- Simultaneous alloc and dealloc (different entries): count unchanged. Upd to an invalid entry with state 0 has no count effect.
- Upd and alloc targeting the same index in the same cycle: alloc wins.
- Invack: inv_load has priority over inv_dec. inv_dec saturates at 0. Both act on upd_idx, qualified by upd_valid.
- Lookup: lowest matching index wins on multiple hits; lkp_idx is 0 when no hit.
- Forward: on fwd_valid with lkp_hit, fwd_stall_idx <= lkp_idx next edge, and fwd_stall is set or cleared by kind:
  - PUTACK: clear.
  - INV: set iff entry state == ISD_ST, else clear.
  - other: clear iff state == MIA_ST, else set.
- Forward miss: fwd_valid with no hit clears fwd_stall.
- Stall release: fwd_stall also clears when entry fwd_stall_idx is deallocated. A forward probe in the same cycle takes priority.
- Reads and lookups see pre-edge contents; no bypass.
- Reset may assert at any time; it aborts all entries immediately.

Optional Feature:
- Macro: L2_REQS_MSHR_PERF_EN.
- When defined: adds outputs peak_count (IDX_BITS+1) and reject_cnt (16 bits).
  - peak_count is a running maximum of count.
  - reject_cnt increments, saturating at 0xFFFF, on each alloc_valid & !alloc_ready cycle.
  - Both reset to 0.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then 4 allocs with N_REQS=4 (tags 0x10..0x13, set 5) -> alloc_idx 0,1,2,3; count 4; full=1; alloc_ready=0. A 5th alloc is ignored and, with PERF, reject_cnt=1.
- Dealloc entry 1, then alloc tag 0x20 in the same cycle as dealloc of entry 3 -> the new entry goes to index 1; count stays 3; conf_set=5 gives conf_hit=1; conf_set=6 gives conf_hit=0.
- Entry 0 with inv_load 3 then four inv_dec cycles -> rd_invack 3,2,1,0,0. inv_load 2 together with inv_dec -> 2.
- Entry 2 in ISD_ST, fwd INV hit -> fwd_stall=1, fwd_stall_idx=2. Dealloc entry 2 -> fwd_stall=0 next cycle.
- Entry in MIA_ST, fwd kind 0 -> fwd_stall=0. Entry in another non-zero state, kind 0 -> stall=1; then PUTACK to the same entry -> 0.
- Assert rst mid-sequence with count=3 -> all outputs at reset values immediately; empty=1.
